// File: rtl/synth_pkg.sv
// Shared types and defaults for the tone/envelope voice path.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int ENV_W_DEFAULT         = 8;
  localparam int ATTACK_STEP_DEFAULT   = 50000;
  localparam int DECAY_STEP_DEFAULT    = 50000;
  localparam int RELEASE_STEP_DEFAULT  = 100000;
  localparam int SUSTAIN_LEVEL_DEFAULT = 192;

  // Index of the lowest set bit (0 when none set); supports up to 32 inputs.
  function automatic int lowest_set_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pwm_modulator.sv
// Free-running W-bit PWM: output high while counter < duty and gate is high.
module pwm_modulator #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] duty,
  input  logic         gate,
  output logic         pwm_out
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= gate && (cnt < duty);
    end
  end

endmodule

// File: rtl/tone_envelope_pwm.sv
// Priority-selected tone with ADSR envelope driving a PWM audio pin.
// Optional macro TONE_ENV_KEY_SYNC_EN adds a 2-flop key_in synchroniser.
module tone_envelope_pwm
  import synth_pkg::*;
#(
  parameter int NUM_TONES     = 8,
  parameter int ENV_W         = ENV_W_DEFAULT,
  parameter int ATTACK_STEP   = ATTACK_STEP_DEFAULT,
  parameter int DECAY_STEP    = DECAY_STEP_DEFAULT,
  parameter int RELEASE_STEP  = RELEASE_STEP_DEFAULT,
  parameter int SUSTAIN_LEVEL = SUSTAIN_LEVEL_DEFAULT,
  localparam int IDX_W        = $clog2(NUM_TONES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_TONES-1:0] tone_in,
  input  logic [NUM_TONES-1:0] key_in,
  output logic                 pwm_out,
  output logic [ENV_W-1:0]     env_level,
  output logic [IDX_W-1:0]     active_idx,
  output logic                 voice_busy
);

  localparam int MAX_STEP_AD = (ATTACK_STEP > DECAY_STEP) ? ATTACK_STEP : DECAY_STEP;
  localparam int MAX_STEP    = (MAX_STEP_AD > RELEASE_STEP) ? MAX_STEP_AD : RELEASE_STEP;
  localparam int CNT_W       = (MAX_STEP > 2) ? $clog2(MAX_STEP) : 1;

  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [ENV_W-1:0] SUS_LVL = ENV_W'(SUSTAIN_LEVEL);

  function automatic logic [ENV_W-1:0] sat_inc(input logic [ENV_W-1:0] v);
    return (v == ENV_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [ENV_W-1:0] sat_dec(input logic [ENV_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic [NUM_TONES-1:0] key_s;

`ifdef TONE_ENV_KEY_SYNC_EN
  logic [NUM_TONES-1:0] key_meta_p0, key_sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_p0 <= '0;
      key_sync_p1 <= '0;
    end else begin
      key_meta_p0 <= key_in;
      key_sync_p1 <= key_meta_p0;
    end
  end

  assign key_s = key_sync_p1;
`else
  assign key_s = key_in;
`endif

  logic             any_key;
  env_state_t       state, state_nx;
  logic [ENV_W-1:0] level_nx;
  logic [CNT_W-1:0] step_cnt, step_len;
  logic             counting, tick;

  assign any_key    = |key_s;
  assign voice_busy = (state != IDLE);

  always_comb begin
    step_len = '0;
    counting = 1'b0;
    case (state)
      ATTACK:  begin step_len = CNT_W'(ATTACK_STEP - 1);  counting = 1'b1; end
      DECAY:   begin step_len = CNT_W'(DECAY_STEP - 1);   counting = 1'b1; end
      RELEASE: begin step_len = CNT_W'(RELEASE_STEP - 1); counting = 1'b1; end
      default: ;
    endcase
  end

  assign tick = counting && (step_cnt == step_len);

  // Key events are tested first so they win over a level threshold in the same cycle.
  always_comb begin
    state_nx = state;
    level_nx = env_level;
    case (state)
      IDLE: begin
        level_nx = '0;
        if (any_key) state_nx = ATTACK;
      end
      ATTACK: begin
        if (!any_key) state_nx = RELEASE;
        else if (env_level == ENV_MAX) state_nx = DECAY;
        else if (tick) begin
          level_nx = sat_inc(env_level);
          if (level_nx == ENV_MAX) state_nx = DECAY;
        end
      end
      DECAY: begin
        if (!any_key) state_nx = RELEASE;
        else if (env_level <= SUS_LVL) state_nx = SUSTAIN;
        else if (tick) begin
          level_nx = sat_dec(env_level);
          if (level_nx <= SUS_LVL) state_nx = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (!any_key) state_nx = RELEASE;
      end
      RELEASE: begin
        if (any_key) state_nx = ATTACK;
        else if (env_level == '0) state_nx = IDLE;
        else if (tick) level_nx = sat_dec(env_level);
      end
      default: begin
        state_nx = IDLE;
        level_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      env_level  <= '0;
      step_cnt   <= '0;
      active_idx <= '0;
    end else begin
      state     <= state_nx;
      env_level <= level_nx;
      if ((state_nx != state) || tick || !counting) step_cnt <= '0;
      else step_cnt <= step_cnt + 1'b1;
      // Legato: index follows the keys, but holds through the release tail.
      if (any_key) active_idx <= IDX_W'(lowest_set_idx(32'(key_s)));
    end
  end

  logic pwm_gate;
  assign pwm_gate = tone_in[active_idx] & voice_busy;

  pwm_modulator #(.W(ENV_W)) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .duty    (env_level),
    .gate    (pwm_gate),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Directed + randomized bench for tone_envelope_pwm against a behavioural envelope model.
module tb_tone_envelope_pwm;

  localparam int NT = 8, EW = 4, AS = 4, DS = 2, RS = 8, SL = 12, EMAX = 15;
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NT-1:0] tone_in = '0;
  logic [NT-1:0] key_in = '0;
  logic          pwm_out;
  logic [EW-1:0] env_level;
  logic [2:0]    active_idx;
  logic          voice_busy;

  int tests = 0;
  int fails = 0;
  bit rand_tone = 1'b1;

  always #5 clk = ~clk;

  tone_envelope_pwm #(
    .NUM_TONES(NT), .ENV_W(EW), .ATTACK_STEP(AS), .DECAY_STEP(DS),
    .RELEASE_STEP(RS), .SUSTAIN_LEVEL(SL)
  ) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in), .key_in(key_in),
    .pwm_out(pwm_out), .env_level(env_level), .active_idx(active_idx),
    .voice_busy(voice_busy)
  );

  // Reference model: phase, level, time spent in phase, selected note, PWM.
  int   m_phase, m_level, m_age, m_idx, m_cnt;
  logic m_pwm;

  function automatic int lowest(input logic [NT-1:0] k);
    for (int i = 0; i < NT; i++) if (k[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_level = 0; m_age = 0; m_idx = 0; m_cnt = 0; m_pwm = 1'b0;
  endtask

  task automatic model_step();
    bit any;
    int per, nxt;
    bit tick;
    any   = (key_in != '0);
    m_pwm = (tone_in[m_idx] == 1'b1) && (m_phase != P_IDLE) && (m_cnt < m_level);
    m_cnt = (m_cnt + 1) % (EMAX + 1);
    if (any) m_idx = lowest(key_in);
    per  = (m_phase == P_ATT) ? AS : (m_phase == P_DEC) ? DS : (m_phase == P_REL) ? RS : 0;
    tick = (per != 0) && (((m_age + 1) % per) == 0);
    nxt  = m_phase;
    case (m_phase)
      P_IDLE: if (any) nxt = P_ATT;
      P_ATT: begin
        if (!any) nxt = P_REL;
        else if (m_level == EMAX) nxt = P_DEC;
        else if (tick) begin
          m_level++;
          if (m_level == EMAX) nxt = P_DEC;
        end
      end
      P_DEC: begin
        if (!any) nxt = P_REL;
        else if (m_level <= SL) nxt = P_SUS;
        else if (tick) begin
          m_level--;
          if (m_level <= SL) nxt = P_SUS;
        end
      end
      P_SUS: if (!any) nxt = P_REL;
      default: begin
        if (any) nxt = P_ATT;
        else if (m_level == 0) nxt = P_IDLE;
        else if (tick) m_level--;
      end
    endcase
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("env_level", 32'(env_level), 32'(m_level));
      chk("voice_busy", 32'(voice_busy), 32'(m_phase != P_IDLE));
      chk("active_idx", 32'(active_idx), 32'(m_idx));
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      if (rand_tone) tone_in = NT'($urandom);
    end
  endtask

  initial begin
    int hi;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_env", 32'(env_level), 0);
    chk("reset_busy", 32'(voice_busy), 0);
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_idx", 32'(active_idx), 0);
    reset = 1'b0;
    run(4);

    // Attack sweep to peak, decay to sustain
    key_in = 8'b0000_0100;
    run(61);
    chk("attack_peak", 32'(env_level), 15);
    chk("attack_idx", 32'(active_idx), 2);
    run(6);
    chk("decay_floor", 32'(env_level), 12);
    run(10);
    chk("sustain_hold", 32'(env_level), 12);

    // Release tail
    key_in = '0;
    run(97);
    chk("release_zero", 32'(env_level), 0);
    chk("release_busy_tail", 32'(voice_busy), 1);
    run(1);
    chk("release_idle", 32'(voice_busy), 0);
    chk("release_idx", 32'(active_idx), 2);

    // Retrigger during release
    key_in = 8'b0000_0100;
    run(69);
    key_in = '0;
    run(57);
    chk("retrig_level5", 32'(env_level), 5);
    key_in = 8'b0000_0100;
    run(1);
    chk("retrig_hold", 32'(env_level), 5);
    run(4);
    chk("retrig_rise", 32'(env_level), 6);

    // Priority and legato
    key_in = 8'b0010_1000;
    run(1);
    chk("prio_idx3", 32'(active_idx), 3);
    chk("legato_level", 32'(env_level), 6);
    key_in = 8'b0010_0000;
    run(1);
    chk("prio_idx5", 32'(active_idx), 5);
    chk("legato_busy", 32'(voice_busy), 1);

    // PWM duty at sustain and at zero level
    run(60);
    rand_tone = 1'b0;
    tone_in = '1;
    run(2);
    hi = 0;
    for (int c = 0; c < 16; c++) begin
      run(1);
      hi += int'(pwm_out);
    end
    chk("pwm_duty12", 32'(hi), 12);
    key_in = '0;
    run(100);
    hi = 0;
    for (int c = 0; c < 16; c++) begin
      run(1);
      hi += int'(pwm_out);
    end
    chk("pwm_duty0", 32'(hi), 0);

    // Asynchronous reset in sustain
    key_in = 8'b0000_0001;
    run(72);
    chk("pre_reset_sustain", 32'(env_level), 12);
    #2 reset = 1'b1;
    #1;
    chk("async_env", 32'(env_level), 0);
    chk("async_pwm", 32'(pwm_out), 0);
    chk("async_busy", 32'(voice_busy), 0);
    model_reset();
    key_in = '0;
    @(negedge clk);
    reset = 1'b0;
    run(2);
    chk("post_reset_idle", 32'(voice_busy), 0);

    // Randomized key activity
    rand_tone = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0)
        key_in = ($urandom_range(0, 2) == 0) ? '0 : NT'($urandom);
      run(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_envelope_pwm.md
Name: tone_envelope_pwm

Overview:
- Downstream consumer of the per-note square-wave tone timers.
- Selects one tone from NUM_TONES square-wave inputs by key priority and shapes its loudness with an attack/decay/sustain/release envelope.
- Drives a single speaker/audio pin through a PWM modulator.
- Sits between the bank of tone timers and the board audio output.

Parameters:
- NUM_TONES, 8: number of tone inputs and keys.
- ENV_W, 8: envelope level width; ENV_MAX = 2^ENV_W-1.
- ATTACK_STEP, 50000: clk cycles per +1 level step in ATTACK.
- DECAY_STEP, 50000: clk cycles per -1 level step in DECAY.
- RELEASE_STEP, 100000: clk cycles per -1 level step in RELEASE.
- SUSTAIN_LEVEL, 192: hold level while a key is held; must be < ENV_MAX.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tone_in  in  NUM_TONES  square waves from the tone timers; bit i = note i.
- key_in  in  NUM_TONES  key pressed, active-high; bit i gates note i.
- pwm_out  out  1  registered PWM audio output.
- env_level  out  ENV_W  current envelope level.
- active_idx  out  clog2(NUM_TONES)  index of the currently selected note.
- voice_busy  out  1  high in every state except IDLE.

Interface decision: reset is asynchronous, active-high; clock is clk.

Behaviour:
- Reset values: pwm_out=0, env_level=0, active_idx=0, voice_busy=0, state=IDLE, step counter=0, PWM counter=0.
- Key priority: the lowest set bit of key_in wins.
  - any_key = |key_in.
  - When any_key=1, active_idx updates on the next clock edge to the winning index; legato, so the envelope is not restarted on a key change.
  - When any_key=0, active_idx holds its last value, so the release tail plays the last note.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
  - IDLE: env_level=0. any_key -> ATTACK.
  - ATTACK: +1 per ATTACK_STEP cycles. At ENV_MAX -> DECAY. !any_key -> RELEASE.
  - DECAY: -1 per DECAY_STEP. At SUSTAIN_LEVEL -> SUSTAIN. !any_key -> RELEASE.
  - SUSTAIN: level held. !any_key -> RELEASE.
  - RELEASE: -1 per RELEASE_STEP. At 0 -> IDLE. any_key -> ATTACK, starting from the current level with no jump to 0.
- Step counter: counts 0..STEP-1 for the current state; the tick fires when count==STEP-1. The counter clears on every state transition.
- Level arithmetic saturates: never above ENV_MAX, never below 0, no wrap.
  - If a release starts at level 0, RELEASE -> IDLE on the next cycle.
- Simultaneous events: a key event (press/release) takes priority over a level-threshold transition in the same cycle.
- PWM:
  - Free-running ENV_W-bit counter, wraps ENV_MAX->0.
  - pwm_out <= tone_in[active_idx] & voice_busy & (pwm_cnt < env_level); one cycle of latency.
  - env_level=0 gives constant 0. env_level=ENV_MAX gives high for ENV_MAX of every 2^ENV_W cycles while the tone is high.
- Reset mid-operation: all state returns to reset values immediately; pwm_out drops asynchronously.

Optional Feature:
- Macro: TONE_ENV_KEY_SYNC_EN.
- Defined: key_in passes through a 2-flop synchroniser before priority selection, adding 2 cycles of latency to all key-driven transitions. Synchroniser flops reset to 0.
- Undefined: key_in is used directly and must be synchronous to clk.

Decomposition:
- Shared package (synth_pkg):
  - env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).
  - ENV_W_DEFAULT.
  - Step defaults.
  - A function returning the lowest-set-bit index.
- Sub-module pwm_modulator: free-running counter plus compare, with parameter W and ports clk, reset, duty, gate, pwm_out.

Test Plan (sim params: ATTACK_STEP=4, DECAY_STEP=2, RELEASE_STEP=8, ENV_W=4, SUSTAIN_LEVEL=12):
- Reset check: reset asserted mid-SUSTAIN -> env_level=0, pwm_out=0, voice_busy=0 within the same cycle; IDLE after release of reset.
- Attack sweep: key_in=8'b0000_0100 held -> active_idx=2; env_level reaches 15 after 60 cycles of ATTACK, then decays to 12 after 6 more cycles, then holds.
- Release: in SUSTAIN, key_in->0 -> level drops 1 per 8 cycles; reaches 0 after 96 cycles; voice_busy=0 one cycle later; active_idx stays 2.
- Retrigger: key pressed again at level 5 during RELEASE -> ATTACK resumes from 5, with no dip to 0.
- Priority/legato: keys 3 and 5 pressed together -> active_idx=3; release key 3 -> active_idx=5; env_level continues without restart.
- PWM duty: tone_in all-high, env_level held at 12 -> pwm_out high exactly 12 of every 16 cycles; env_level=0 -> pwm_out constant 0.
